// File: rtl/floo_serial_link_deframer_pkg.sv
// floo_serial_link_deframer_pkg: shared types and helpers for the serial link rx deframer
package floo_serial_link_deframer_pkg;
  typedef enum logic [0:0] {DfIdle = 1'b0, DfCollect = 1'b1} deframe_state_e;
  function automatic int num_beats(input int flit_w, input int beat_w);
    return (flit_w + beat_w - 1) / beat_w;
  endfunction
endpackage

// File: rtl/floo_serial_link_rx_fifo.sv
// floo_serial_link_rx_fifo: registered-head FIFO with arbitrary depth and occupancy count
module floo_serial_link_rx_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           data_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] fill_o
);
  localparam int unsigned PtrW = Depth > 1 ? $clog2(Depth) : 1;
  localparam int unsigned FillW = $clog2(Depth + 1);
  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0] wr_q, rd_q;
  logic [FillW-1:0] fill_q;
  logic push_ok, pop_ok;
  function automatic logic [PtrW-1:0] wrap_inc(input logic [PtrW-1:0] p);
    return p == PtrW'(Depth - 1) ? '0 : p + 1'b1;
  endfunction
  assign full_o = fill_q == FillW'(Depth);
  assign empty_o = fill_q == '0;
  assign fill_o = fill_q;
  assign pop_ok = pop_i && !empty_o;
  // a push into a full FIFO is legal only when the head leaves in the same cycle
  assign push_ok = push_i && (!full_o || pop_ok);
  assign data_o = empty_o ? '0 : mem_q[rd_q];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
      fill_q <= '0;
    end else begin
      if (push_ok) wr_q <= wrap_inc(wr_q);
      if (pop_ok) rd_q <= wrap_inc(rd_q);
      fill_q <= fill_q + FillW'(push_ok) - FillW'(pop_ok);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/floo_serial_link_rx_deframer.sv
// floo_serial_link_rx_deframer: reassembles rx beats into flits, buffers them and returns credits
module floo_serial_link_rx_deframer
  import floo_serial_link_deframer_pkg::*;
#(
  parameter int unsigned FlitWidth = 64,
  parameter int unsigned BeatWidth = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       beat_valid_i,
  input  logic                       beat_sof_i,
  input  logic [BeatWidth-1:0]       beat_data_i,
  output logic                       flit_valid_o,
  input  logic                       flit_ready_i,
  output logic [FlitWidth-1:0]       flit_o,
  output logic                       credit_o,
  input  logic                       clear_err_i,
  output logic                       overflow_err_o,
  output logic                       framing_err_o,
  output logic [$clog2(Depth+1)-1:0] fill_o
);
  localparam int unsigned NumBeats = num_beats(FlitWidth, BeatWidth);
  localparam int unsigned CntW = NumBeats > 1 ? $clog2(NumBeats) : 1;
  deframe_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, slot;
  logic [NumBeats*BeatWidth-1:0] buf_q, asm_frame;
  logic start, cont, stray, last, done, pop, push, full, empty, credit_q, ovf_q, ferr_q;
  assign start = beat_valid_i && beat_sof_i;
  assign cont = beat_valid_i && !beat_sof_i && state_q == DfCollect;
  assign stray = beat_valid_i && !beat_sof_i && state_q == DfIdle;
  assign last = cnt_q == CntW'(NumBeats - 1);
  assign done = (start && NumBeats == 1) || (cont && last);
  assign slot = start ? '0 : cnt_q;
  // current beat bypasses the storage so the flit is pushed on its last beat
  always_comb begin
    asm_frame = buf_q;
    asm_frame[slot*BeatWidth +: BeatWidth] = beat_data_i;
  end
  always_comb begin
    state_d = state_q;
    if (start) state_d = NumBeats == 1 ? DfIdle : DfCollect;
    else if (cont && last) state_d = DfIdle;
  end
  assign cnt_d = start ? CntW'(NumBeats > 1) : cont ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
  assign pop = flit_valid_o && flit_ready_i;
  assign push = done && (!full || pop);
  assign flit_valid_o = !empty;
  assign credit_o = credit_q;
  assign overflow_err_o = ovf_q;
  assign framing_err_o = ferr_q;
  floo_serial_link_rx_fifo #(
    .Width(FlitWidth),
    .Depth(Depth)
  ) i_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (push),
    .data_i (asm_frame[FlitWidth-1:0]),
    .pop_i  (pop),
    .data_o (flit_o),
    .full_o (full),
    .empty_o(empty),
    .fill_o (fill_o)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= DfIdle;
      cnt_q <= '0;
      buf_q <= '0;
      credit_q <= 1'b0;
      ovf_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (start || cont) buf_q <= asm_frame;
      credit_q <= pop;
      ovf_q <= (done && full && !pop) || (ovf_q && !clear_err_i);
      ferr_q <= stray || (start && state_q == DfCollect) || (ferr_q && !clear_err_i);
    end
  end
endmodule

// File: tb/tb_floo_serial_link_rx_deframer.sv
// tb_floo_serial_link_rx_deframer: scoreboard bench for the default and an odd-width deframer
module tb_floo_serial_link_rx_deframer;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;
  logic beat_valid_i = 0, beat_sof_i = 0, flit_ready_i = 0, clear_err_i = 0;
  logic [7:0] beat_data_i = '0;
  logic flit_valid_o, credit_o, overflow_err_o, framing_err_o;
  logic [63:0] flit_o;
  logic [2:0] fill_o;
  logic o_valid = 0, o_sof = 0, o_ready = 1;
  logic [7:0] o_data = '0;
  logic o_fvalid, o_credit, o_ovf, o_ferr;
  logic [19:0] o_flit;
  logic [1:0] o_fill;
  int total = 0, bad = 0, cred_cnt = 0;
  bit last_pop = 0, prev_stall = 0;
  logic [63:0] prev_flit = '0;
  logic [63:0] q[$];

  floo_serial_link_rx_deframer dut (
    .clk_i(clk), .rst_i(rst_i), .beat_valid_i(beat_valid_i), .beat_sof_i(beat_sof_i),
    .beat_data_i(beat_data_i), .flit_valid_o(flit_valid_o), .flit_ready_i(flit_ready_i),
    .flit_o(flit_o), .credit_o(credit_o), .clear_err_i(clear_err_i),
    .overflow_err_o(overflow_err_o), .framing_err_o(framing_err_o), .fill_o(fill_o)
  );

  floo_serial_link_rx_deframer #(.FlitWidth(20), .BeatWidth(8), .Depth(2)) dut_odd (
    .clk_i(clk), .rst_i(rst_i), .beat_valid_i(o_valid), .beat_sof_i(o_sof),
    .beat_data_i(o_data), .flit_valid_o(o_fvalid), .flit_ready_i(o_ready),
    .flit_o(o_flit), .credit_o(o_credit), .clear_err_i(1'b0),
    .overflow_err_o(o_ovf), .framing_err_o(o_ferr), .fill_o(o_fill)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_i) begin
      last_pop = 0;
      prev_stall = 0;
    end else begin
      chk("credit", 64'(credit_o), 64'(last_pop));
      if (credit_o) cred_cnt++;
      if (prev_stall) begin
        chk("hold_valid", 64'(flit_valid_o), 64'd1);
        chk("hold_flit", flit_o, prev_flit);
      end
      last_pop = flit_valid_o && flit_ready_i;
      prev_stall = flit_valid_o && !flit_ready_i;
      prev_flit = flit_o;
      if (last_pop) begin
        if (q.size() == 0) chk("sb_nonempty", 64'd0, 64'd1);
        else chk("flit", flit_o, q.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(input bit sof, input logic [7:0] d);
    beat_valid_i = 1; beat_sof_i = sof; beat_data_i = d;
    @(posedge clk); #1;
    beat_valid_i = 0; beat_sof_i = 0;
  endtask

  task automatic frame(input logic [63:0] f, input bit exp, input int gap);
    if (exp) q.push_back(f);
    for (int k = 0; k < 8; k++) begin
      beat(k == 0, f[k*8 +: 8]);
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic drain(input string tag);
    flit_ready_i = 1;
    for (int i = 0; i < 40 && q.size() != 0; i++) idle(1);
    idle(2);
    chk(tag, 64'(q.size()), 64'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 64'(flit_valid_o), 64'd0);
    chk({tag, "_flit"}, flit_o, 64'd0);
    chk({tag, "_credit"}, 64'(credit_o), 64'd0);
    chk({tag, "_ovf"}, 64'(overflow_err_o), 64'd0);
    chk({tag, "_ferr"}, 64'(framing_err_o), 64'd0);
    chk({tag, "_fill"}, 64'(fill_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] f;
    int c0;
    repeat (3) @(posedge clk);
    #1 rst_i = 0;
    chk_zero("rst");
    // single frame, then one with idle gaps between beats
    flit_ready_i = 1;
    frame(64'h0807060504030201, 1, 0);
    chk("lat_valid", 64'(flit_valid_o), 64'd1);
    idle(3);
    chk("cred_single", 64'(cred_cnt), 64'd1);
    chk("single_ovf", 64'(overflow_err_o), 64'd0);
    chk("single_ferr", 64'(framing_err_o), 64'd0);
    frame(64'h0123456789ABCDEF, 1, 2);
    drain("drain_gap");
    // overflow: fifth frame into a full FIFO is dropped
    c0 = cred_cnt;
    flit_ready_i = 0;
    for (int i = 0; i < 5; i++) frame(64'h1111111111111111 * (i + 1), i < 4, 0);
    idle(1);
    chk("ovf_fill", 64'(fill_o), 64'd4);
    chk("ovf_flag", 64'(overflow_err_o), 64'd1);
    drain("drain_ovf");
    chk("ovf_credits", 64'(cred_cnt - c0), 64'd4);
    chk("ovf_fill0", 64'(fill_o), 64'd0);
    clear_err_i = 1; idle(1); clear_err_i = 0;
    chk("ovf_clear", 64'(overflow_err_o), 64'd0);
    // full FIFO with pop in the cycle the next frame completes
    flit_ready_i = 0;
    for (int i = 0; i < 4; i++) frame(64'hA0A0A0A0A0A0A0A0 + 64'(i), 1, 0);
    f = 64'h5A5A5A5A5A5A5A5A;
    q.push_back(f);
    for (int k = 0; k < 7; k++) beat(k == 0, f[k*8 +: 8]);
    flit_ready_i = 1;
    beat(0, f[63:56]);
    flit_ready_i = 0;
    chk("popfull_fill", 64'(fill_o), 64'd4);
    chk("popfull_ovf", 64'(overflow_err_o), 64'd0);
    drain("drain_popfull");
    // framing: truncated frame restarted by a new SOF
    beat(1, 8'hA0);
    for (int k = 0; k < 3; k++) beat(0, 8'hB0 + 8'(k));
    frame(64'h1817161514131211, 1, 0);
    idle(2);
    chk("frm_flag", 64'(framing_err_o), 64'd1);
    drain("drain_frm");
    clear_err_i = 1; idle(1); clear_err_i = 0;
    chk("frm_clear", 64'(framing_err_o), 64'd0);
    beat(0, 8'h55);
    chk("frm_stray", 64'(framing_err_o), 64'd1);
    clear_err_i = 1;
    beat(0, 8'h66);
    clear_err_i = 0;
    chk("frm_set_wins", 64'(framing_err_o), 64'd1);
    clear_err_i = 1; idle(1); clear_err_i = 0;
    chk("frm_clear2", 64'(framing_err_o), 64'd0);
    // reset in the middle of a frame discards it
    beat(1, 8'hEE);
    for (int k = 0; k < 3; k++) beat(0, 8'hE0 + 8'(k));
    rst_i = 1; idle(1);
    chk_zero("midrst");
    rst_i = 0;
    frame(64'hCAFEBABEDEADBEEF, 1, 0);
    drain("drain_midrst");
    chk("midrst_ferr", 64'(framing_err_o), 64'd0);
    // odd width: top bits of the last beat are dropped
    o_valid = 1; o_sof = 1; o_data = 8'hAB; idle(1);
    o_sof = 0; o_data = 8'hCD; idle(1);
    o_data = 8'hFE; idle(1);
    o_valid = 0;
    chk("odd_valid", 64'(o_fvalid), 64'd1);
    chk("odd_flit", 64'(o_flit), 64'hECDAB);
    idle(1);
    chk("odd_credit", 64'(o_credit), 64'd1);
    chk("odd_ferr", 64'(o_ferr), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
